// File: rtl/ps_config_pkg.sv
// Shared types and constants for the passive-serial configuration receiver and its loader.
package ps_config_pkg;

    typedef enum logic [2:0] {
        CFG_RESET   = 3'd0,
        WAIT_STATUS = 3'd1,
        RECEIVE     = 3'd2,
        DONE        = 3'd3,
        ERROR       = 3'd4
    } ps_rx_state_t;

    localparam logic [3:0] MSEL_PS_DEFAULT = 4'b0000;

    // Nominal nSTATUS release delay; the loader waits at least this long.
    localparam int PS_STATUS_DELAY_NOM = 20;

endpackage

// File: rtl/ps_sync.sv
// Two-flop synchronizer with a rising-edge pulse taken from the synchronized level.
module ps_sync (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/ps_receiver.sv
// Passive-serial configuration target: syncs nCONFIG/DCLK/DATA, shifts bits LSB first into
// DW-bit words and hands them to a valid/ready consumer until IMAGE_WORDS have been accepted.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   CFG_RESET   | target held in reset, counters cleared, waits nCONFIG rise
//   WAIT_STATUS | down-counting the nSTATUS release delay
//   RECEIVE     | shifting DCLK bits into words, handing words downstream
//   DONE        | image complete, CONF_DONE high, DCLK ignored
//   ERROR       | bad MSEL or word overflow, left only via nCONFIG low
module ps_receiver
    import ps_config_pkg::*;
#(
    parameter int         DW           = 64,
    parameter int         IMAGE_WORDS  = 1024,
    parameter int         STATUS_DELAY = PS_STATUS_DELAY_NOM,
    parameter logic [3:0] MSEL_PS      = MSEL_PS_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          n_config,
    input  logic          dclk,
    input  logic          data,
    input  logic          n_ce,
    input  logic [3:0]    msel,
    output logic          n_status,
    output logic          conf_done,
    output logic [DW-1:0] word,
    output logic          word_valid,
    input  logic          word_ready,
    output logic          error,
    output logic          done
);

    localparam int BW  = (DW > 1) ? $clog2(DW) : 1;
    localparam int WCW = $clog2(IMAGE_WORDS + 1);
    localparam int TW  = (STATUS_DELAY > 1) ? $clog2(STATUS_DELAY) : 1;

    localparam logic [BW-1:0]  BIT_LAST  = BW'(DW - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(IMAGE_WORDS - 1);
    localparam logic [TW-1:0]  TMR_LOAD  = TW'(STATUS_DELAY - 1);

    ps_rx_state_t   state_q, state_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [DW-1:0]  shift_q, shift_d;
    logic [DW-1:0]  word_q, word_d;
    logic           word_valid_q, word_valid_d;
    logic           full_q, full_d;
    logic           done_q, done_d;

    logic ncfg_s1_q, ncfg_s2_q, ncfg_s3_q;
    logic data_s1_q, data_s2_q;
    logic nce_s1_q, nce_s2_q;
    logic dclk_rise;
    logic ncfg_rise;
    logic accept;

    ps_sync u_dclk_sync (
        .clock  (clock),
        .reset  (reset),
        .d_i    (dclk),
        .rise_o (dclk_rise)
    );

    // data and n_ce take the same two stages as dclk so they line up with its edge pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ncfg_s1_q <= 1'b0;
            ncfg_s2_q <= 1'b0;
            ncfg_s3_q <= 1'b0;
            data_s1_q <= 1'b0;
            data_s2_q <= 1'b0;
            nce_s1_q  <= 1'b1;
            nce_s2_q  <= 1'b1;
        end else begin
            ncfg_s1_q <= n_config;
            ncfg_s2_q <= ncfg_s1_q;
            ncfg_s3_q <= ncfg_s2_q;
            data_s1_q <= data;
            data_s2_q <= data_s1_q;
            nce_s1_q  <= n_ce;
            nce_s2_q  <= nce_s1_q;
        end
    end

    assign ncfg_rise = ncfg_s2_q & ~ncfg_s3_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= CFG_RESET;
            tmr_q        <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            full_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            full_q       <= full_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        shift_d      = shift_q;
        word_d       = word_q;
        word_valid_d = word_valid_q;
        full_d       = 1'b0;
        done_d       = 1'b0;
        accept       = word_valid_q & word_ready;

        unique case (state_q)
            CFG_RESET: begin
                bit_cnt_d    = '0;
                word_cnt_d   = '0;
                word_valid_d = 1'b0;
                if (ncfg_rise) begin
                    if (msel == MSEL_PS) begin
                        state_d = WAIT_STATUS;
                        tmr_d   = TMR_LOAD;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            WAIT_STATUS: begin
                if (tmr_q == '0) begin
                    state_d = RECEIVE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            RECEIVE: begin
                if (accept) begin
                    word_valid_d = 1'b0;
                    word_cnt_d   = word_cnt_q + WCW'(1);
                    if (word_cnt_q == WORD_LAST) begin
                        state_d = DONE;
                    end
                end
                // A word completing while the previous one is accepted is a hand-over, not an overflow.
                if (full_q) begin
                    if (!word_valid_q || accept) begin
                        word_d       = shift_q;
                        word_valid_d = 1'b1;
                    end else begin
                        state_d = ERROR;
                    end
                end
                if (dclk_rise && !nce_s2_q) begin
                    shift_d[bit_cnt_q] = data_s2_q;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        full_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            DONE: begin
            end
            ERROR: begin
            end
            default: begin
                state_d = CFG_RESET;
            end
        endcase

        if (!ncfg_s2_q) begin
            state_d      = CFG_RESET;
            bit_cnt_d    = '0;
            word_cnt_d   = '0;
            word_valid_d = 1'b0;
            full_d       = 1'b0;
        end

        done_d = (state_d == DONE) && (state_q != DONE);
    end

    assign n_status   = (state_q == RECEIVE) || (state_q == DONE);
    assign conf_done  = (state_q == DONE);
    assign error      = (state_q == ERROR);
    assign done       = done_q;
    assign word       = word_q;
    assign word_valid = word_valid_q;

endmodule

// File: doc/ps_receiver.md
# ps_receiver

Target-side endpoint of the passive-serial (PS) configuration interface. It emulates the configured device's PS slave: it accepts nCONFIG/DCLK/DATA/nCE/MSEL from a PS loader, drives nSTATUS and CONF_DONE, and assembles the serial bitstream into DW-bit words for a downstream consumer such as a BRAM image store or checker. It is used as a bench-level and in-fabric partner for the team's PS loader, and as a soft-configuration sink.

## Interface
- `DW`, 64, word width; bits are received LSB first (bit 0 of a word arrives first).
- `IMAGE_WORDS`, 1024, number of words in a complete image; CONF_DONE asserts after this many words are accepted.
- `STATUS_DELAY`, 20, clock cycles from the synchronized nCONFIG rise to the nSTATUS release.
- `MSEL_PS`, 4'b0000, the only MSEL value accepted as PS mode.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `n_config` in 1: configuration request from the loader; low means reset the target.
- `dclk` in 1: serial clock; may be asynchronous to `clock`.
- `data` in 1: serial data, sampled on the DCLK rise.
- `n_ce` in 1: chip enable, active low; DCLK is ignored while it is high.
- `msel` in 4: mode select, checked at the nCONFIG rise.
- `n_status` out 1: low while in reset or error; open-drain semantics are modelled as plain logic.
- `conf_done` out 1: image complete.
- `word` out DW: assembled word.
- `word_valid` out 1: `word` holds an unaccepted word.
- `word_ready` in 1: consumer accepts `word` when `word_valid && word_ready`.
- `error` out 1: the block is in the ERROR state.
- `done` out 1: single-cycle pulse on entry to DONE.

## Operation
- Inputs `n_config`, `dclk`, `data` pass through a 2-flop synchronizer. The DCLK rising edge is detected when the synchronized DCLK sees 0 then 1. `data` is delayed by the same amount so that it stays aligned with DCLK.
- States:
  - CFG_RESET: `n_status`=0, `conf_done`=0, bit and word counters at 0, `word_valid`=0. Exit to WAIT_STATUS on the synchronized `n_config` rise if `msel==MSEL_PS`; otherwise go to ERROR.
  - WAIT_STATUS: count STATUS_DELAY cycles, then go to RECEIVE with `n_status`=1.
  - RECEIVE: on each DCLK rise with `n_ce`=0, write `shift[bit_cnt]` from `data` and increment `bit_cnt`. When bit DW-1 is captured:
    - If `word_valid` is clear: load `word` from the shift register, set `word_valid`, and clear `bit_cnt`.
    - If `word_valid` is set (overflow): go to ERROR.
  - RECEIVE, word handshake: each accept (`word_valid && word_ready`) clears `word_valid` and increments `word_cnt`. When the accept makes `word_cnt` equal IMAGE_WORDS, go to DONE.
  - DONE: `conf_done`=1 and `n_status`=1. Further DCLK edges are ignored.
  - ERROR: `n_status`=0 and `error`=1. DCLK is ignored.
- Synchronized `n_config` low in any state forces CFG_RESET on the next cycle. This includes mid-word, WAIT_STATUS, DONE and ERROR. A partial word is discarded and a pending `word_valid` is dropped.
- Simultaneous events:
  - A word completes in the same cycle it is accepted: the old word is accepted and the new word is loaded. This is not an overflow.
  - `n_config` low and a DCLK edge in the same cycle: `n_config` wins.
- ERROR is left only through `n_config` low.
- `word_cnt` is $clog2(IMAGE_WORDS+1) bits wide, and `bit_cnt` is $clog2(DW) bits wide.

## Timing
- Reset values: `n_status`=0, `conf_done`=0, `word`=0, `word_valid`=0, `error`=0, `done`=0, state CFG_RESET.
- Latency from a raw `dclk` rise to the bit being stored is 3 cycles: 2 synchronizer cycles plus the edge register.
- `word_valid` rises 1 cycle after the last bit is stored.
- Latency from a raw `n_config` rise to `n_status` high is 2 + 1 + STATUS_DELAY cycles.
- `conf_done` rises the cycle after the final accept. `done` pulses in that same cycle.
- DCLK high and low phases must each last at least 1 `clock` cycle when the source shares `clock`. They must last at least 2 cycles when the source is asynchronous.
- `data` must be stable from the DCLK rise until 2 cycles after it.

## Structure
- Package `ps_config_pkg` holds:
  - the `ps_rx_state_t` enum (CFG_RESET, WAIT_STATUS, RECEIVE, DONE, ERROR);
  - the `MSEL_PS` default;
  - the nominal status-delay constant shared with the loader.
- Sub-module `ps_sync`: a 2-flop synchronizer with rising-edge output. It is instantiated for `dclk`, with plain sync paths for `n_config` and `data`.

## Test plan
- Reset with `reset` pulsed mid-run: all outputs return to their reset values within 0 cycles. The reset is asynchronous.
- Nominal load with DW=8, IMAGE_WORDS=2, STATUS_DELAY=4, `word_ready`=1:
  - hold `n_config` low for 3 cycles, then release; `n_status` rises 7 cycles after the release;
  - shift 0xA5 then 0x3C LSB first; `word` shows 0xA5 then 0x3C, each with a 1-cycle `word_valid`;
  - `conf_done`=1 and `done` pulses.
- MSEL mismatch: `msel`=4'b0010 at the nCONFIG rise gives `n_status` held low and `error`=1. Any DCLK traffic produces no words.
- Overflow: hold `word_ready`=0 and send 16 bits with DW=8. `word` stays at the first word, `error` rises 1 cycle after bit 15, and `n_status`=0.
- nCONFIG pulse after 5 bits, then a fresh load of 0x81: `word`=0x81 and the stale bits are not merged.
- `n_ce`=1 during 8 DCLK pulses, then 0 for 8 pulses of 0xFF: exactly one word (0xFF) is produced.
